// File: rtl/nic_seq_pkg.sv
// Shared definitions for the NIC init sequencer: NIC register offsets, FSM states, step indexing.
package nic_seq_pkg;

   localparam logic [31:0] REG_RDBAL = 32'h0000_2800;
   localparam logic [31:0] REG_RDBAH = 32'h0000_2804;
   localparam logic [31:0] REG_RDLEN = 32'h0000_2808;
   localparam logic [31:0] REG_TDBAL = 32'h0000_3800;
   localparam logic [31:0] REG_TDBAH = 32'h0000_3804;
   localparam logic [31:0] REG_TDLEN = 32'h0000_3808;
   localparam logic [31:0] REG_CTRL  = 32'h0000_0100;

   localparam int NUM_STEPS = 6;

   typedef logic [2:0] step_t;

   localparam step_t LAST_STEP = step_t'(NUM_STEPS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_DONE,
      S_CTRL_ISSUE,
      S_CTRL_WAIT,
      S_ERROR
   } state_t;

endpackage

// File: rtl/nic_seq_step_rom.sv
// Combinational map from ring-programming step to NIC register offset and write data.
module nic_seq_step_rom
   import nic_seq_pkg::*;
#(
   parameter int unsigned RING_ENTRIES = 256,
   parameter int unsigned DESC_BYTES   = 16,
   parameter logic [31:0] RX_RING_OFF  = 32'h0000_0000,
   parameter logic [31:0] TX_RING_OFF  = 32'h0000_1000
) (
   input  step_t       step_i,
   input  logic [31:0] fpga_base_i,
   output logic [31:0] offset_o,
   output logic [31:0] data_o
);

   localparam logic [31:0] RING_BYTES = 32'(RING_ENTRIES * DESC_BYTES);

   // Descriptor rings live below 4 GiB of FPGA memory, so the high base words are zero.
   always_comb begin
      offset_o = '0;
      data_o   = '0;
      case (step_i)
         3'd0: begin offset_o = REG_RDBAL; data_o = fpga_base_i + RX_RING_OFF; end
         3'd1: begin offset_o = REG_RDBAH; data_o = '0;                        end
         3'd2: begin offset_o = REG_RDLEN; data_o = RING_BYTES;                end
         3'd3: begin offset_o = REG_TDBAL; data_o = fpga_base_i + TX_RING_OFF; end
         3'd4: begin offset_o = REG_TDBAH; data_o = '0;                        end
         3'd5: begin offset_o = REG_TDLEN; data_o = RING_BYTES;                end
         default: ;
      endcase
   end

endmodule

// File: rtl/nic_init_sequencer.sv
// Programs NIC RX/TX descriptor rings on init, then mirrors start_i into the NIC CTRL register.
// Optional response timeout in the wait states is enabled by defining NIC_SEQ_TIMEOUT_EN.
module nic_init_sequencer
   import nic_seq_pkg::*;
#(
   parameter int unsigned RING_ENTRIES   = 256,
   parameter int unsigned DESC_BYTES     = 16,
   parameter logic [31:0] RX_RING_OFF    = 32'h0000_0000,
   parameter logic [31:0] TX_RING_OFF    = 32'h0000_1000,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        init_i,
   input  logic        start_i,
   input  logic [63:0] nic_base_addr_i,
   input  logic [31:0] fpga_base_addr_i,
   output logic        wr_valid_o,
   input  logic        wr_ready_i,
   output logic [63:0] wr_addr_o,
   output logic [31:0] wr_data_o,
   input  logic        wr_resp_valid_i,
   input  logic        wr_resp_err_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o,
   output logic        nic_enabled_o
);

   state_t      state_q, state_d;
   step_t       step_q, step_d;
   logic [63:0] nic_base_q, nic_base_d;
   logic [31:0] fpga_base_q, fpga_base_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic        en_q, en_d;
   logic        ctrl_q, ctrl_d;
   logic        tmo_hit;

   logic [31:0] rom_offset, rom_data;

   nic_seq_step_rom #(
      .RING_ENTRIES(RING_ENTRIES),
      .DESC_BYTES  (DESC_BYTES),
      .RX_RING_OFF (RX_RING_OFF),
      .TX_RING_OFF (TX_RING_OFF)
   ) u_rom (
      .step_i     (step_q),
      .fpga_base_i(fpga_base_q),
      .offset_o   (rom_offset),
      .data_o     (rom_data)
   );

`ifdef NIC_SEQ_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tmo_q, tmo_d;

   assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES - 1));

   // Counts cycles spent in a wait state; any transition (including entry) restarts it.
   always_comb begin
      tmo_d = '0;
      if ((state_q == S_WAIT || state_q == S_CTRL_WAIT) && state_d == state_q)
         tmo_d = tmo_q + TW'(1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) tmo_q <= '0;
      else       tmo_q <= tmo_d;
   end
`else
   logic [31:0] unused_timeout;
   assign unused_timeout = 32'(TIMEOUT_CYCLES);
   assign tmo_hit        = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      step_d      = step_q;
      nic_base_d  = nic_base_q;
      fpga_base_d = fpga_base_q;
      done_d      = done_q;
      err_d       = err_q;
      en_d        = en_q;
      ctrl_d      = ctrl_q;
      case (state_q)
         S_IDLE, S_DONE, S_ERROR: begin
            if (init_i) begin
               state_d     = S_ISSUE;
               step_d      = '0;
               nic_base_d  = nic_base_addr_i;
               fpga_base_d = fpga_base_addr_i;
               done_d      = 1'b0;
               err_d       = 1'b0;
               en_d        = 1'b0;
            end else if (state_q == S_DONE && start_i != en_q) begin
               state_d = S_CTRL_ISSUE;
               ctrl_d  = start_i;
            end
         end
         S_ISSUE:      if (wr_ready_i) state_d = S_WAIT;
         S_CTRL_ISSUE: if (wr_ready_i) state_d = S_CTRL_WAIT;
         S_WAIT, S_CTRL_WAIT: begin
            if (wr_resp_valid_i && !wr_resp_err_i) begin
               if (state_q == S_CTRL_WAIT) begin
                  state_d = S_DONE;
                  en_d    = ctrl_q;
               end else if (step_q == LAST_STEP) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_ISSUE;
                  step_d  = step_q + step_t'(1);
               end
            end else if (wr_resp_valid_i || tmo_hit) begin
               // NIC state is unknown after a failed write, so enable is reported as off.
               state_d = S_ERROR;
               err_d   = 1'b1;
               done_d  = 1'b0;
               en_d    = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         step_q      <= '0;
         nic_base_q  <= '0;
         fpga_base_q <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         en_q        <= 1'b0;
         ctrl_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         step_q      <= step_d;
         nic_base_q  <= nic_base_d;
         fpga_base_q <= fpga_base_d;
         done_q      <= done_d;
         err_q       <= err_d;
         en_q        <= en_d;
         ctrl_q      <= ctrl_d;
      end
   end

   logic        in_ctrl;
   logic [31:0] offset, data;

   assign in_ctrl = (state_q == S_CTRL_ISSUE);
   assign offset  = in_ctrl ? REG_CTRL : rom_offset;
   assign data    = in_ctrl ? {31'b0, ctrl_q} : rom_data;

   assign wr_valid_o    = (state_q == S_ISSUE) || in_ctrl;
   assign wr_addr_o     = wr_valid_o ? (nic_base_q + {32'b0, offset}) : '0;
   assign wr_data_o     = wr_valid_o ? data : '0;
   assign busy_o        = (state_q == S_ISSUE) || (state_q == S_WAIT) ||
                          (state_q == S_CTRL_ISSUE) || (state_q == S_CTRL_WAIT);
   assign done_o        = done_q;
   assign err_o         = err_q;
   assign nic_enabled_o = en_q;

endmodule

// File: tb/tb_nic_init_sequencer.sv
// Directed self-checking bench for nic_init_sequencer; define NIC_SEQ_TIMEOUT_EN to add the timeout case.
module tb_nic_init_sequencer;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        init_i = 1'b0;
   logic        start_i = 1'b0;
   logic [63:0] nic_base_addr_i = '0;
   logic [31:0] fpga_base_addr_i = '0;
   logic        wr_valid_o;
   logic        wr_ready_i = 1'b0;
   logic [63:0] wr_addr_o;
   logic [31:0] wr_data_o;
   logic        wr_resp_valid_i = 1'b0;
   logic        wr_resp_err_i = 1'b0;
   logic        busy_o, done_o, err_o, nic_enabled_o;

   int checks = 0;
   int errors = 0;

   nic_init_sequencer #(.TIMEOUT_CYCLES(16)) dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .init_i          (init_i),
      .start_i         (start_i),
      .nic_base_addr_i (nic_base_addr_i),
      .fpga_base_addr_i(fpga_base_addr_i),
      .wr_valid_o      (wr_valid_o),
      .wr_ready_i      (wr_ready_i),
      .wr_addr_o       (wr_addr_o),
      .wr_data_o       (wr_data_o),
      .wr_resp_valid_i (wr_resp_valid_i),
      .wr_resp_err_i   (wr_resp_err_i),
      .busy_o          (busy_o),
      .done_o          (done_o),
      .err_o           (err_o),
      .nic_enabled_o   (nic_enabled_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_init();
      init_i = 1'b1;
      @(negedge clk_i);
      init_i = 1'b0;
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!wr_valid_o && n < 40) begin
         @(negedge clk_i);
         n++;
      end
   endtask

   // One complete write: wait for request, optional ready stall, accept, then respond next cycle.
   task automatic do_write(input string tag, input logic [63:0] ea, input logic [31:0] ed,
                           input int stall, input logic err);
      wr_ready_i = 1'b0;
      wait_valid();
      check({tag, "_valid"}, wr_valid_o, 1);
      check({tag, "_addr"}, wr_addr_o, ea);
      check({tag, "_data"}, wr_data_o, ed);
      for (int i = 0; i < stall; i++) begin
         @(negedge clk_i);
         check({tag, "_hold_addr"}, wr_addr_o, ea);
         check({tag, "_hold_data"}, wr_data_o, ed);
      end
      wr_ready_i = 1'b1;
      @(negedge clk_i);
      wr_ready_i = 1'b0;
      check({tag, "_valid_low_in_wait"}, wr_valid_o, 0);
      wr_resp_valid_i = 1'b1;
      wr_resp_err_i   = err;
      @(negedge clk_i);
      wr_resp_valid_i = 1'b0;
      wr_resp_err_i   = 1'b0;
   endtask

   task automatic check_idle_bus(input string tag);
      logic seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk_i);
         seen = seen | wr_valid_o;
      end
      check(tag, seen, 0);
   endtask

   initial begin
      repeat (3) @(negedge clk_i);
      check("rst_valid", wr_valid_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);
      check("rst_err", err_o, 0);
      check("rst_en", nic_enabled_o, 0);
      rst_i = 1'b0;
      @(negedge clk_i);

      // Ring programming with immediate ready/response; bases change after init to prove latching.
      nic_base_addr_i  = 64'h0000_00F0_0000_0000;
      fpga_base_addr_i = 32'h8000_0000;
      pulse_init();
      check("init_latency_valid", wr_valid_o, 1);
      check("init_busy", busy_o, 1);
      nic_base_addr_i  = 64'h1234_5678_0000_0000;
      fpga_base_addr_i = 32'h0BAD_0000;
      do_write("s0", 64'h0000_00F0_0000_2800, 32'h8000_0000, 0, 0);
      do_write("s1", 64'h0000_00F0_0000_2804, 32'h0000_0000, 0, 0);
      do_write("s2", 64'h0000_00F0_0000_2808, 32'h0000_1000, 0, 0);
      do_write("s3", 64'h0000_00F0_0000_3800, 32'h8000_1000, 0, 0);
      do_write("s4", 64'h0000_00F0_0000_3804, 32'h0000_0000, 0, 0);
      do_write("s5", 64'h0000_00F0_0000_3808, 32'h0000_1000, 0, 0);
      check("seq_done", done_o, 1);
      check("seq_done_busy", busy_o, 0);

      // Enable follows start_i through the CTRL register.
      start_i = 1'b1;
      do_write("ctrl_on", 64'h0000_00F0_0000_0100, 32'h1, 0, 0);
      check("ctrl_on_en", nic_enabled_o, 1);
      check("ctrl_on_busy", busy_o, 0);
      check("ctrl_on_done", done_o, 1);
      start_i = 1'b0;
      do_write("ctrl_off", 64'h0000_00F0_0000_0100, 32'h0, 0, 0);
      check("ctrl_off_en", nic_enabled_o, 0);

      // Wrapping TDBAL data, ready stall at step 3, then error response.
      nic_base_addr_i  = 64'h0000_0001_0000_0000;
      fpga_base_addr_i = 32'hFFFF_F800;
      pulse_init();
      check("reinit_done_clr", done_o, 0);
      do_write("e0", 64'h0000_0001_0000_2800, 32'hFFFF_F800, 0, 0);
      do_write("e1", 64'h0000_0001_0000_2804, 32'h0000_0000, 0, 0);
      do_write("e2", 64'h0000_0001_0000_2808, 32'h0000_1000, 0, 0);
      do_write("e3", 64'h0000_0001_0000_3800, 32'h0000_0800, 5, 1);
      check("err_set", err_o, 1);
      check("err_done", done_o, 0);
      check("err_busy", busy_o, 0);
      check_idle_bus("err_no_more_writes");

      // Restart from error; an init mid-sequence must be ignored.
      pulse_init();
      check("restart_err_clr", err_o, 0);
      check("restart_busy", busy_o, 1);
      do_write("r0", 64'h0000_0001_0000_2800, 32'hFFFF_F800, 0, 0);
      do_write("r1", 64'h0000_0001_0000_2804, 32'h0000_0000, 0, 0);
      fpga_base_addr_i = 32'h0000_0000;
      pulse_init();
      do_write("r2", 64'h0000_0001_0000_2808, 32'h0000_1000, 0, 0);
      do_write("r3", 64'h0000_0001_0000_3800, 32'h0000_0800, 0, 0);
      do_write("r4", 64'h0000_0001_0000_3804, 32'h0000_0000, 0, 0);
      do_write("r5", 64'h0000_0001_0000_3808, 32'h0000_1000, 0, 0);
      check("restart_done", done_o, 1);
      check_idle_bus("done_once");

      // Reset while waiting for a response.
      fpga_base_addr_i = 32'h8000_0000;
      pulse_init();
      do_write("x0", 64'h0000_0001_0000_2800, 32'h8000_0000, 0, 0);
      wait_valid();
      wr_ready_i = 1'b1;
      @(negedge clk_i);
      wr_ready_i = 1'b0;
      rst_i = 1'b1;
      @(negedge clk_i);
      check("midrst_valid", wr_valid_o, 0);
      check("midrst_busy", busy_o, 0);
      check("midrst_done", done_o, 0);
      check("midrst_err", err_o, 0);
      check("midrst_addr", wr_addr_o, 0);
      check("midrst_data", wr_data_o, 0);
      rst_i = 1'b0;
      @(negedge clk_i);
      pulse_init();
      check("postrst_step0_addr", wr_addr_o, 64'h0000_0001_0000_2800);

`ifdef NIC_SEQ_TIMEOUT_EN
      // Response withheld: ERROR after 16 cycles in WAIT; the late response changes nothing.
      wr_ready_i = 1'b1;
      @(negedge clk_i);
      wr_ready_i = 1'b0;
      repeat (15) @(negedge clk_i);
      check("tmo_not_yet", err_o, 0);
      @(negedge clk_i);
      check("tmo_err", err_o, 1);
      wr_resp_valid_i = 1'b1;
      @(negedge clk_i);
      wr_resp_valid_i = 1'b0;
      @(negedge clk_i);
      check("tmo_late_err", err_o, 1);
      check("tmo_late_valid", wr_valid_o, 0);
      check("tmo_late_done", done_o, 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
